// File: rtl/gsim_host_if_if.sv
// Bundles the host write/result port and the solver stream port of gsim_host_if.
// The slave modport is the view taken by gsim_host_if itself.
interface gsim_host_if_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        start;
    logic        gs_in_en;
    logic [15:0] gs_b_in;
    logic        gs_out_valid;
    logic [31:0] gs_x_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic        busy;
    logic        done;
    logic        timeout_err;

    modport slave (
        input  wr_en, wr_data, start, gs_out_valid, gs_x_out, res_ready,
        output gs_in_en, gs_b_in, res_valid, res_data, res_last, busy, done, timeout_err
    );

    modport master (
        output wr_en, wr_data, start, gs_out_valid, gs_x_out, res_ready,
        input  gs_in_en, gs_b_in, res_valid, res_data, res_last, busy, done, timeout_err
    );
endinterface

// File: rtl/gsim_host_if.sv
// Host-side companion of the Gauss-Seidel solver: buffers b, bursts it to the solver,
// captures the x result set and returns it to the host with ready/valid back-pressure.
module gsim_host_if #(
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic            clk,
    input logic            reset,
    gsim_host_if_if.slave  bus
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wr_cnt;
    logic [CW-1:0]   r_cap_cnt;
    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_wait_cnt;
    logic [15:0]     r_bbuf [N];
    logic [31:0]     r_xbuf [N];

    logic            r_gs_in_en;
    logic [15:0]     r_gs_b_in;
    logic            r_res_valid;
    logic [31:0]     r_res_data;
    logic            r_res_last;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout_err;

    logic            w_wr_accept;
    logic            w_cap;
    logic [IW-1:0]   w_cap_idx;
    logic            w_hs;
    logic            w_last_idx;

    assign w_wr_accept = (r_state == S_IDLE) && bus.wr_en && (r_wr_cnt != CW'(N));
    assign w_cap       = ((r_state == S_WAIT) || (r_state == S_CAPTURE)) && bus.gs_out_valid;
    assign w_cap_idx   = (r_state == S_WAIT) ? '0 : r_cap_cnt[IW-1:0];
    assign w_hs        = r_res_valid && bus.res_ready;
    assign w_last_idx  = (r_idx == IW'(N - 1));

    // Buffer storage carries no reset; contents are meaningless until rewritten.
    always_ff @(posedge clk) begin
        if (w_wr_accept)
            r_bbuf[r_wr_cnt[IW-1:0]] <= bus.wr_data;
        if (w_cap)
            r_xbuf[w_cap_idx] <= bus.gs_x_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_cnt      <= '0;
            r_cap_cnt     <= '0;
            r_idx         <= '0;
            r_wait_cnt    <= '0;
            r_gs_in_en    <= 1'b0;
            r_gs_b_in     <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Start only counts against the fill level seen before this cycle's write.
                    if (bus.start && (r_wr_cnt == CW'(N))) begin
                        r_state       <= S_SEND;
                        r_idx         <= '0;
                        r_gs_in_en    <= 1'b1;
                        r_gs_b_in     <= r_bbuf[0];
                        r_busy        <= 1'b1;
                        r_timeout_err <= 1'b0;
                    end else if (w_wr_accept) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                    end
                end
                S_SEND: begin
                    if (w_last_idx) begin
                        r_state    <= S_WAIT;
                        r_gs_in_en <= 1'b0;
                        r_gs_b_in  <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_idx     <= r_idx + IW'(1);
                        r_gs_b_in <= r_bbuf[r_idx + IW'(1)];
                    end
                end
                S_WAIT: begin
                    if (bus.gs_out_valid) begin
                        r_state   <= S_CAPTURE;
                        r_cap_cnt <= CW'(1);
                    end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                        r_state       <= S_IDLE;
                        r_timeout_err <= 1'b1;
                        r_wr_cnt      <= '0;
                        r_busy        <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (bus.gs_out_valid) begin
                        r_cap_cnt <= r_cap_cnt + CW'(1);
                        if (r_cap_cnt == CW'(N - 1)) begin
                            r_state     <= S_DRAIN;
                            r_idx       <= '0;
                            r_res_valid <= 1'b1;
                            r_res_data  <= r_xbuf[0];
                            r_res_last  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        if (w_last_idx) begin
                            r_state     <= S_IDLE;
                            r_res_valid <= 1'b0;
                            r_res_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_wr_cnt    <= '0;
                        end else begin
                            r_idx      <= r_idx + IW'(1);
                            r_res_data <= r_xbuf[r_idx + IW'(1)];
                            r_res_last <= (r_idx == IW'(N - 2));
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gs_in_en    = r_gs_in_en;
    assign bus.gs_b_in     = r_gs_b_in;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_last    = r_res_last;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_gsim_host_if.sv
// Scoreboard bench for gsim_host_if: a vector-level host/solver model queues expected
// burst entries and result words; a negedge monitor pops and compares them.
module tb_gsim_host_if;

    localparam int N       = 16;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gsim_host_if_if bus();

    gsim_host_if #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } res_t;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_b[$];
    res_t        exp_x[$];
    logic [15:0] mb[N];
    int          mcnt     = 0;
    bit          ready_rand = 1'b0;
    int          hs_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int          run_len    = 0;
    bit          prev_en    = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    bit          exp_done   = 1'b0;
    res_t        mon_e;

    always @(negedge clk) begin
        if (reset) begin
            run_len    = 0;
            prev_en    = 1'b0;
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            if (bus.gs_in_en) begin
                chk("b_expected", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0)
                    chk("b_data", 32'(bus.gs_b_in), 32'(exp_b.pop_front()));
                run_len++;
            end else if (prev_en) begin
                chk("burst_len", 32'(run_len), 32'(N));
                run_len = 0;
            end
            prev_en = bus.gs_in_en;

            if (bus.done || exp_done)
                chk("done_pulse", 32'(bus.done), 32'(exp_done));
            if (bus.done)
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            exp_done = 1'b0;

            if (bus.res_valid) begin
                if (prev_stall)
                    chk("stall_hold", bus.res_data, prev_data);
                if (bus.res_ready) begin
                    chk("res_expected", 32'(exp_x.size() != 0), 32'd1);
                    if (exp_x.size() != 0) begin
                        mon_e = exp_x.pop_front();
                        chk("res_data", bus.res_data, mon_e.data);
                        chk("res_last", 32'(bus.res_last), 32'(mon_e.last));
                        exp_done = mon_e.last;
                    end
                    hs_count++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = bus.res_data;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- host / solver model ----------------
    task automatic host_write(input logic [15:0] v, input bit with_start);
        bit acc;
        acc = (mcnt == N);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        bus.start   = with_start;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        if (mcnt < N) begin
            mb[mcnt] = v;
            mcnt++;
        end
        if (with_start && acc)
            for (int i = 0; i < N; i++) exp_b.push_back(mb[i]);
    endtask

    task automatic host_start();
        bit acc;
        acc = (mcnt == N);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (acc)
            for (int i = 0; i < N; i++) exp_b.push_back(mb[i]);
    endtask

    task automatic load_vec(input bit ramp);
        for (int i = 0; i < N; i++)
            host_write(ramp ? 16'(i + 1) : 16'($urandom), 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_en"},   32'(bus.gs_in_en),    32'd0);
        chk({tag, "_b_in"},    32'(bus.gs_b_in),     32'd0);
        chk({tag, "_rvalid"},  32'(bus.res_valid),   32'd0);
        chk({tag, "_rdata"},   bus.res_data,         32'd0);
        chk({tag, "_rlast"},   32'(bus.res_last),    32'd0);
        chk({tag, "_busy"},    32'(bus.busy),        32'd0);
        chk({tag, "_done"},    32'(bus.done),        32'd0);
        chk({tag, "_tmo"},     32'(bus.timeout_err), 32'd0);
    endtask

    task automatic run_solve(input int delay, input int gap_at, input int gap_len,
                             input bit ramp, input bit bp);
        int   cyc;
        int   vcyc;
        int   h0;
        res_t r;
        cyc = 0;
        while (exp_b.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("burst_consumed", 32'(exp_b.size()), 32'd0);
        repeat (delay) tick();
        h0 = hs_count;
        for (int k = 0; k < N; k++) begin
            if (k == gap_at) begin
                bus.gs_out_valid = 1'b0;
                repeat (gap_len) tick();
            end
            bus.gs_out_valid = 1'b1;
            bus.gs_x_out     = ramp ? (32'(k + 1) << 16) : $urandom;
            r.data = bus.gs_x_out;
            r.last = (k == N - 1);
            exp_x.push_back(r);
            tick();
        end
        bus.gs_out_valid = 1'b0;
        ready_rand = bp;
        cyc  = 0;
        vcyc = 0;
        while (!bus.done && cyc < 1000) begin
            if (bus.res_valid) vcyc++;
            tick();
            cyc++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        if (!bp) chk("drain_cycles", 32'(vcyc), 32'(N));
        chk("handshakes", 32'(hs_count - h0), 32'(N));
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("results_consumed", 32'(exp_x.size()), 32'd0);
        ready_rand = 1'b0;
        mcnt = 0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.start        = 1'b0;
        bus.gs_out_valid = 1'b0;
        bus.gs_x_out     = '0;
        bus.res_ready    = 1'b1;
        fork
            forever begin
                @(posedge clk);
                #1;
                bus.res_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic solve: ramp b, ramp x about 1616 cycles after start
        load_vec(1'b1);
        host_start();
        chk("busy_rise", 32'(bus.busy), 32'd1);
        chk("in_en_rise", 32'(bus.gs_in_en), 32'd1);
        run_solve(1600, -1, 0, 1'b1, 1'b0);

        // Incomplete load, write+start in one cycle, dropped 17th write
        for (int i = 0; i < N - 1; i++) host_write(16'($urandom), 1'b0);
        host_start();
        tick();
        chk("short_busy", 32'(bus.busy), 32'd0);
        chk("short_in_en", 32'(bus.gs_in_en), 32'd0);
        host_write(16'($urandom), 1'b1);
        tick();
        chk("wrstart_busy", 32'(bus.busy), 32'd0);
        host_write(16'($urandom), 1'b0);
        host_start();
        run_solve(20, -1, 0, 1'b0, 1'b0);

        // Back-pressure
        load_vec(1'b0);
        host_start();
        run_solve(30, -1, 0, 1'b0, 1'b1);

        // Timeout then recovery
        load_vec(1'b0);
        host_start();
        begin
            int cnt;
            cnt = 0;
            while (bus.busy && cnt < 6000) begin
                cnt++;
                tick();
            end
            chk("timeout_cycles", 32'(cnt), 32'(N + TIMEOUT));
        end
        chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
        chk("timeout_idle", 32'(bus.busy), 32'd0);
        mcnt = 0;
        load_vec(1'b0);
        chk("timeout_err_held", 32'(bus.timeout_err), 32'd1);
        host_start();
        chk("timeout_err_clr", 32'(bus.timeout_err), 32'd0);
        run_solve(10, -1, 0, 1'b0, 1'b0);

        // Stray valid in IDLE, then gapped capture
        for (int i = 0; i < 3; i++) begin
            bus.gs_out_valid = 1'b1;
            bus.gs_x_out     = $urandom;
            tick();
        end
        bus.gs_out_valid = 1'b0;
        tick();
        chk("stray_busy", 32'(bus.busy), 32'd0);
        chk("stray_rvalid", 32'(bus.res_valid), 32'd0);
        load_vec(1'b0);
        host_start();
        run_solve(5, 5, 3, 1'b0, 1'b0);

        // Reset while sending entry 7
        load_vec(1'b0);
        host_start();
        repeat (7) tick();
        chk("pre_reset_in_en", 32'(bus.gs_in_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        exp_b.delete();
        exp_x.delete();
        mcnt = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        load_vec(1'b0);
        host_start();
        run_solve(40, -1, 0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
